// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a big-endian byte stream into 32-bit words and writes them
// from address 0 upward, holding the CPU frozen until the load completes.
module imem_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [ADDR_W:0] word_count_i,
    input  logic            byte_valid_i,
    input  logic [7:0]      byte_data_i,
    output logic            byte_ready_o,
    output logic            mem_we_o,
    output logic [31:0]     mem_addr_o,
    output logic [31:0]     mem_wdata_o,
    output logic            cpu_hold_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o
);

    typedef enum logic [1:0] {StIdle, StCollect, StWrite, StDone} state_e;

    localparam logic [ADDR_W:0]   MaxCnt = (ADDR_W + 1)'(MAX_WORDS);
    localparam logic [ADDR_W:0]   CntOne = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] IdxOne = ADDR_W'(1);

    state_e            state_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W-1:0] word_idx_q;
    logic [1:0]        byte_cnt_q;
    logic [31:0]       shift_q;
    logic              byte_ready_q;
    logic              mem_we_q;
    logic [31:0]       mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic              cpu_hold_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic start_ok;
    logic last_word;

    assign start_ok  = (word_count_i != '0) && (word_count_i <= MaxCnt);
    assign last_word = ({1'b0, word_idx_q} == (count_q - CntOne));

    // Outputs are registered alongside the state so mem_we is glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            count_q      <= '0;
            word_idx_q   <= '0;
            byte_cnt_q   <= '0;
            shift_q      <= '0;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_hold_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            done_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        if (start_ok) begin
                            count_q      <= word_count_i;
                            word_idx_q   <= '0;
                            byte_cnt_q   <= '0;
                            err_q        <= 1'b0;
                            state_q      <= StCollect;
                            byte_ready_q <= 1'b1;
                            cpu_hold_q   <= 1'b1;
                            busy_q       <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                StCollect: begin
                    // byte_ready is high throughout this state, so valid alone is a transfer.
                    if (byte_valid_i) begin
                        shift_q    <= {shift_q[23:0], byte_data_i};
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            state_q      <= StWrite;
                            byte_ready_q <= 1'b0;
                            mem_we_q     <= 1'b1;
                            mem_addr_q   <= {{(30 - ADDR_W){1'b0}}, word_idx_q, 2'b00};
                            mem_wdata_q  <= {shift_q[23:0], byte_data_i};
                        end
                    end
                end
                StWrite: begin
                    if (last_word) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end else begin
                        word_idx_q   <= word_idx_q + IdxOne;
                        byte_cnt_q   <= '0;
                        state_q      <= StCollect;
                        byte_ready_q <= 1'b1;
                    end
                end
                StDone: begin
                    state_q    <= StIdle;
                    cpu_hold_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
            if (start_i && (state_q != StIdle)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign byte_ready_o = byte_ready_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign cpu_hold_o   = cpu_hold_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of load requests with random byte streams checked against a
// byte-packing model, plus cycle-exact, busy-start and mid-load-reset sequences.
module tb_imem_loader;

    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned MAX_WORDS = 256;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start_i;
    logic [ADDR_W:0]   word_count_i;
    logic              byte_valid_i;
    logic [7:0]        byte_data_i;
    logic              byte_ready_o;
    logic              mem_we_o;
    logic [31:0]       mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic              cpu_hold_o;
    logic              busy_o;
    logic              done_o;
    logic              err_o;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];

    typedef struct {
        int unsigned cnt;
        int unsigned gap;
        bit          poke;
        bit          ok;
    } vec_t;

    vec_t vecs[8];

    imem_loader #(
        .ADDR_W   (ADDR_W),
        .MAX_WORDS(MAX_WORDS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .word_count_i(word_count_i),
        .byte_valid_i(byte_valid_i),
        .byte_data_i (byte_data_i),
        .byte_ready_o(byte_ready_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .cpu_hold_o  (cpu_hold_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we_o) begin
            wq_addr.push_back(mem_addr_o);
            wq_data.push_back(mem_wdata_o);
            check("ready low during write", 64'(byte_ready_o), 64'(0));
        end
        if (done_o) done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full load with a random byte stream; called and returns at #1 after a rising edge.
    task automatic run_load(input int unsigned cnt, input int unsigned gap, input bit poke);
        logic [7:0] bq[$];
        logic [31:0] exp_word;
        int idx = 0;
        int cyc = 0;
        int budget;
        bit poked = 0;
        bit accept;
        budget = int'(cnt) * 60 + 100;
        for (int i = 0; i < int'(cnt) * 4; i++) bq.push_back(8'($urandom));
        wq_addr.delete();
        wq_data.delete();
        done_cnt = 0;
        start_i = 1'b1;
        word_count_i = (ADDR_W + 1)'(cnt);
        step();
        start_i = 1'b0;
        check("start accepted {busy,err}", 64'({busy_o, err_o}), 64'(2'b10));
        while (idx < bq.size() && cyc < budget) begin
            byte_valid_i = ($urandom_range(99) >= gap);
            byte_data_i  = byte_valid_i ? bq[idx] : 8'($urandom);
            if (poke && !poked && idx == 6) begin
                start_i = 1'b1;
                word_count_i = (ADDR_W + 1)'(1);
                poked = 1;
            end
            accept = byte_valid_i && byte_ready_o;
            step();
            start_i = 1'b0;
            if (accept) idx++;
            cyc++;
        end
        byte_valid_i = 1'b0;
        check("all bytes accepted", 64'(idx), 64'(bq.size()));
        while (done_cnt == 0 && cyc < budget) begin
            step();
            cyc++;
        end
        check("done pulse seen", 64'(done_cnt), 64'(1));
        check("idle after done {hold,busy}", 64'({cpu_hold_o, busy_o}), 64'(0));
        check("err after load", 64'(err_o), 64'(poke));
        check("write count", 64'(wq_addr.size()), 64'(cnt));
        for (int i = 0; i < int'(cnt) && i < wq_addr.size(); i++) begin
            exp_word = {bq[4*i], bq[4*i+1], bq[4*i+2], bq[4*i+3]};
            check("write addr", 64'(wq_addr[i]), 64'(4 * i));
            check("write data", 64'(wq_data[i]), 64'(exp_word));
        end
    endtask

    initial begin
        logic [7:0] hb[4];
        logic [3:0] hexp[8];
        int fed;
        int cyc;
        bit accept;

        vecs[0] = '{cnt: 0,   gap: 0,  poke: 0, ok: 0};
        vecs[1] = '{cnt: 257, gap: 0,  poke: 0, ok: 0};
        vecs[2] = '{cnt: 1,   gap: 0,  poke: 0, ok: 1};
        vecs[3] = '{cnt: 511, gap: 0,  poke: 0, ok: 0};
        vecs[4] = '{cnt: 3,   gap: 40, poke: 0, ok: 1};
        vecs[5] = '{cnt: 2,   gap: 20, poke: 1, ok: 1};
        vecs[6] = '{cnt: 256, gap: 10, poke: 0, ok: 1};
        vecs[7] = '{cnt: 5,   gap: 60, poke: 0, ok: 1};

        hb = '{8'h20, 8'h08, 8'h00, 8'h05};
        // {byte_ready, mem_we, cpu_hold, done} for cycles 1..8
        hexp = '{4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b0110, 4'b0011, 4'b0000, 4'b0000};

        rst_n = 1'b0;
        start_i = 1'b0;
        word_count_i = '0;
        byte_valid_i = 1'b0;
        byte_data_i = '0;
        #2;
        check("reset ctrl outputs",
              64'({byte_ready_o, mem_we_o, cpu_hold_o, busy_o, done_o, err_o}), 64'(0));
        check("reset addr/data", 64'({mem_addr_o, mem_wdata_o}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Back-to-back single-word load with cycle-exact expectations.
        wq_addr.delete();
        wq_data.delete();
        start_i = 1'b1;
        word_count_i = (ADDR_W + 1)'(1);
        for (int e = 0; e < 8; e++) begin
            step();
            start_i = 1'b0;
            byte_valid_i = (e < 4);
            byte_data_i = (e < 4) ? hb[e] : 8'h00;
            check("timed {ready,we,hold,done}",
                  64'({byte_ready_o, mem_we_o, cpu_hold_o, done_o}), 64'(hexp[e]));
            if (e == 4) begin
                check("timed addr", 64'(mem_addr_o), 64'(32'h0));
                check("timed data", 64'(mem_wdata_o), 64'(32'h20080005));
            end
        end
        byte_valid_i = 1'b0;
        check("timed write count", 64'(wq_addr.size()), 64'(1));

        foreach (vecs[v]) begin
            if (vecs[v].ok) begin
                run_load(vecs[v].cnt, vecs[v].gap, vecs[v].poke);
            end else begin
                wq_addr.delete();
                start_i = 1'b1;
                word_count_i = (ADDR_W + 1)'(vecs[v].cnt);
                step();
                start_i = 1'b0;
                check("bad start {busy,err}", 64'({busy_o, err_o}), 64'(2'b01));
                repeat (6) step();
                check("bad start stays idle", 64'({busy_o, cpu_hold_o, err_o}), 64'(3'b001));
                check("bad start no write", 64'(wq_addr.size()), 64'(0));
            end
        end

        // Reset after two bytes of word 1, then a fresh single-word load.
        start_i = 1'b1;
        word_count_i = (ADDR_W + 1)'(2);
        step();
        start_i = 1'b0;
        fed = 0;
        cyc = 0;
        while (fed < 6 && cyc < 50) begin
            byte_valid_i = 1'b1;
            byte_data_i = 8'($urandom);
            accept = byte_ready_o;
            step();
            if (accept) fed++;
            cyc++;
        end
        byte_valid_i = 1'b0;
        check("partial bytes fed", 64'(fed), 64'(6));
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset ctrl outputs",
              64'({byte_ready_o, mem_we_o, cpu_hold_o, busy_o, done_o, err_o}), 64'(0));
        check("async reset addr/data", 64'({mem_addr_o, mem_wdata_o}), 64'(0));
        wq_addr.delete();
        wq_data.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step();
        check("no write after reset", 64'(wq_addr.size()), 64'(0));
        run_load(1, 30, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
